// File: rtl/nrzi_destuff_decoder_if.sv
// Bus between the line sampler (master) and the NRZI de-stuffing decoder (slave).
// Carries the line-bit strobe, the packet sync, and the decoded bit/word/error outputs.
interface nrzi_destuff_decoder_if #(
   parameter int WIDTH = 8
);
   logic             din;
   logic             din_valid;
   logic             sync;
   logic             dout;
   logic             dout_valid;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             stuff_err;

   modport master (
      output din, din_valid, sync,
      input  dout, dout_valid, word, word_valid, stuff_err
   );

   modport slave (
      input  din, din_valid, sync,
      output dout, dout_valid, word, word_valid, stuff_err
   );
endinterface

// File: rtl/nrzi_destuff_decoder.sv
// Receive-side line decoder: NRZI decode, removal of stuffed zeros, and LSB-first
// packing into WIDTH-bit words. All outputs are registered one cycle after the strobe.
module nrzi_destuff_decoder #(
   parameter int   WIDTH      = 8,
   parameter int   STUFF_LEN  = 6,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   nrzi_destuff_decoder_if.slave     bus
);
   localparam int CW = $clog2(STUFF_LEN + 1);
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DROP  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             prev_line_q, prev_line_d;
   logic [CW-1:0]    ones_cnt_q, ones_cnt_d;
   logic [IW-1:0]    bit_idx_q, bit_idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             stuff_err_q, stuff_err_d;
   logic             dec_bit_s;
   logic             emit_s;

   assign dec_bit_s = ~(bus.din ^ prev_line_q);

   // Next-state: sync realign, NRZI decode, stuff-bit FSM and word assembly.
   always_comb begin
      state_d      = state_q;
      prev_line_d  = prev_line_q;
      ones_cnt_d   = ones_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      word_d       = word_q;
      dout_d       = dout_q;
      word_valid_d = 1'b0;
      dout_valid_d = 1'b0;
      stuff_err_d  = 1'b0;
      emit_s       = 1'b0;

      if (bus.sync) begin
         state_d     = ST_RUN;
         prev_line_d = IDLE_LEVEL;
         ones_cnt_d  = '0;
         bit_idx_d   = '0;
      end else if (bus.din_valid) begin
         prev_line_d = bus.din;
         case (state_q)
            ST_RUN: begin
               emit_s = 1'b1;
               if (dec_bit_s) begin
                  if ((ones_cnt_q + CW'(1)) == STUFF_MAX) begin
                     ones_cnt_d = '0;
                     state_d    = ST_DROP;
                  end else begin
                     ones_cnt_d = ones_cnt_q + CW'(1);
                  end
               end else begin
                  ones_cnt_d = '0;
               end
            end
            ST_DROP: begin
               if (dec_bit_s) begin
                  stuff_err_d = 1'b1;
                  state_d     = ST_ERROR;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_ERROR: begin
               state_d = ST_ERROR;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // The word is published from the shift image including the bit just written.
      if (emit_s) begin
         dout_d             = dec_bit_s;
         dout_valid_d       = 1'b1;
         shift_d[bit_idx_q] = dec_bit_s;
         if (bit_idx_q == IDX_LAST) begin
            word_d       = shift_d;
            word_valid_d = 1'b1;
            bit_idx_d    = '0;
         end else begin
            bit_idx_d = bit_idx_q + IW'(1);
         end
      end else begin
         bit_idx_d = bit_idx_d;
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         prev_line_q  <= IDLE_LEVEL;
         ones_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         stuff_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_line_q  <= prev_line_d;
         ones_cnt_q   <= ones_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         stuff_err_q  <= stuff_err_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.word       = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.stuff_err  = stuff_err_q;
endmodule

// File: tb/tb_nrzi_destuff_decoder.sv
// Bench for nrzi_destuff_decoder: directed scenarios plus random line traffic,
// checked every cycle against a stream-level model of decode, de-stuff and packing.
module tb_nrzi_destuff_decoder;
   localparam int WIDTH = 8;
   localparam int SLEN  = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   nrzi_destuff_decoder_if #(.WIDTH(WIDTH)) bus ();

   nrzi_destuff_decoder #(.WIDTH(WIDTH), .STUFF_LEN(SLEN), .IDLE_LEVEL(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model state: the emitted data stream since the last sync/reset.
   bit             m_prev;
   bit             hist[$];
   int             run_start;
   bit             m_err;
   bit             last_din;
   logic           exp_dv, exp_dout, exp_wv, exp_err;
   logic [WIDTH-1:0] exp_word;
   logic           nxt_dv, nxt_dout, nxt_wv, nxt_err;
   logic [WIDTH-1:0] nxt_word;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // A stuff bit is due when the last SLEN emitted bits are all ones and none
   // of them precede the previous dropped stuff bit.
   function automatic bit stuff_due();
      int n = hist.size();
      if (n - run_start < SLEN) return 1'b0;
      for (int k = 1; k <= SLEN; k++)
         if (!hist[n-k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_prev = 1'b1; hist.delete(); run_start = 0; m_err = 1'b0;
      exp_dv = 1'b0; exp_dout = 1'b0; exp_wv = 1'b0; exp_err = 1'b0; exp_word = '0;
   endtask

   task automatic model_eval(input bit din, input bit dv, input bit sy);
      bit d;
      nxt_dv = 1'b0; nxt_wv = 1'b0; nxt_err = 1'b0;
      nxt_dout = exp_dout; nxt_word = exp_word;
      if (sy) begin
         m_prev = 1'b1; hist.delete(); run_start = 0; m_err = 1'b0;
      end else if (dv) begin
         d = (din == m_prev);
         m_prev = din;
         if (!m_err) begin
            if (stuff_due()) begin
               if (d) begin
                  nxt_err = 1'b1;
                  m_err = 1'b1;
               end
               run_start = hist.size();
            end else begin
               hist.push_back(d);
               nxt_dv = 1'b1;
               nxt_dout = d;
               if (hist.size() % WIDTH == 0) begin
                  for (int i = 0; i < WIDTH; i++)
                     nxt_word[i] = hist[hist.size() - WIDTH + i];
                  nxt_wv = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare_outputs();
      check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, exp_dv});
      check("word_valid", {31'd0, bus.word_valid}, {31'd0, exp_wv});
      check("stuff_err",  {31'd0, bus.stuff_err},  {31'd0, exp_err});
      check("word",       {24'd0, bus.word},       {24'd0, exp_word});
      if (exp_dv) check("dout", {31'd0, bus.dout}, {31'd0, exp_dout});
   endtask

   // One clock: drive inputs, advance the model, compare on the falling edge.
   task automatic step(input bit din, input bit dv, input bit sy);
      bus.din = din; bus.din_valid = dv; bus.sync = sy;
      if (dv) last_din = din;
      if (rst_n) model_eval(din, dv, sy);
      else begin
         nxt_dv = 1'b0; nxt_wv = 1'b0; nxt_err = 1'b0; nxt_dout = 1'b0; nxt_word = '0;
      end
      @(posedge clk);
      exp_dv = nxt_dv; exp_dout = nxt_dout; exp_wv = nxt_wv; exp_err = nxt_err; exp_word = nxt_word;
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic feed(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) step(bits[i], 1'b1, 1'b0);
   endtask

   logic [15:0] pat;

   initial begin
      bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
      last_din = 1'b1;
      model_reset();
      @(negedge clk);
      check("rst_dout", {31'd0, bus.dout}, 32'd0);
      check("rst_word", {24'd0, bus.word}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: alternating line -> eight zeros
      pat = 16'b1010_1010; feed(pat, 8);
      check("t1_wv_lit", {31'd0, bus.word_valid}, 32'd1);
      check("t1_word_lit", {24'd0, bus.word}, 32'h00);

      // 2: six ones, stuffed zero dropped, word 0xBF
      step(1'b0, 1'b0, 1'b1);
      pat = 16'b1_1011_1111;
      for (int i = 0; i < 9; i++) begin
         step(pat[i], 1'b1, 1'b0);
         if (i == 6) check("t2_drop_lit", {31'd0, bus.dout_valid}, 32'd0);
      end
      check("t2_word_lit", {24'd0, bus.word}, 32'hBF);
      check("t2_model_lit", {24'd0, exp_word}, 32'hBF);

      // 3: seven ones -> stuff error, sticky until sync
      step(1'b0, 1'b0, 1'b1);
      feed(16'h007F, 7);
      check("t3_err_lit", {31'd0, bus.stuff_err}, 32'd1);
      feed(16'h5A5A, 10);
      step(1'b0, 1'b0, 1'b1);
      feed(16'b1010_1010, 8);
      check("t3_word_lit", {24'd0, bus.word}, 32'h00);

      // 4: partial word dropped by sync colliding with a strobe
      step(1'b0, 1'b0, 1'b1);
      feed(16'b000, 3);
      step(1'b0, 1'b1, 1'b1);
      check("t4_sync_lit", {31'd0, bus.dout_valid}, 32'd0);
      feed(16'b0000_1111, 8);
      check("t4_word_lit", {24'd0, bus.word}, 32'hEF);

      // 5: test-2 data with strobes every third cycle
      step(1'b0, 1'b0, 1'b1);
      pat = 16'b1_1011_1111;
      for (int i = 0; i < 9; i++) begin
         step(pat[i], 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0);
      end
      check("t5_word_lit", {24'd0, bus.word}, 32'hBF);

      // 6: asynchronous reset between edges, mid-word
      step(1'b0, 1'b0, 1'b1);
      feed(16'b1100, 4);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("t6_dout_lit", {31'd0, bus.dout}, 32'd0);
      check("t6_dv_lit", {31'd0, bus.dout_valid}, 32'd0);
      check("t6_word_lit", {24'd0, bus.word}, 32'h00);
      @(negedge clk);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      feed(16'b0000_1111, 8);
      check("t6_restart_lit", {24'd0, bus.word}, 32'hEF);

      // Random traffic biased toward long runs of ones.
      for (int i = 0; i < 3000; i++) begin
         bit dv, sy, din;
         int bias;
         bias = (i / 500) % 2 == 0 ? 85 : 60;
         dv = ($urandom_range(0, 99) < 70);
         sy = ($urandom_range(0, 99) < 2);
         din = ($urandom_range(0, 99) < bias) ? last_din : ~last_din;
         step(din, dv, sy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
